// File: rtl/hdmi_clk_switch_ctrl_pkg.sv
// Shared encodings for the HDMI pixel-clock switch sequencer.
package hdmi_clk_switch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_HOLD     = 3'd3,
        ST_SWITCH   = 3'd4,
        ST_SETTLE   = 3'd5,
        ST_WAIT_CFG = 3'd6
    } sw_state_e;

    localparam logic SEL_MAIN = 1'b0;
    localparam logic SEL_SUB  = 1'b1;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchroniser with synchronous active-low clear.
module cdc_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic SYS_CLK_i,
    input  logic nRST_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge SYS_CLK_i) begin
        if (!nRST_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hdmi_clk_switch_ctrl.sv
// Sequences glitch-safe HDMI pixel-clock mux changes: debounce, hold reset, flip, settle,
// wait for clock-generator config done, release reset.
module hdmi_clk_switch_ctrl
    import hdmi_clk_switch_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned DEBOUNCE_CYC = 1024,
    parameter int unsigned HOLD_CYC     = 64,
    parameter int unsigned SETTLE_CYC   = 256,
    parameter int unsigned TIMEOUT_CYC  = 2**20 - 1
) (
    input  logic SYS_CLK_i,
    input  logic nRST_i,
    input  logic clk_sel_req_i,
    input  logic Si_cfg_done_i,
    output logic HDMI_CLK_sel_o,
    output logic HDMI_hold_nRST_o,
    output logic switching_o,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] DebLoad     = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] HoldLoad    = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] SettleLoad  = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] TimeoutLoad = CNT_W'(TIMEOUT_CYC);

    logic req_s;
    logic cfg_s;

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
        .SYS_CLK_i (SYS_CLK_i),
        .nRST_i    (nRST_i),
        .d_i       (clk_sel_req_i),
        .q_o       (req_s)
    );

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cfg (
        .SYS_CLK_i (SYS_CLK_i),
        .nRST_i    (nRST_i),
        .d_i       (Si_cfg_done_i),
        .q_o       (cfg_s)
    );

    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             hold_q, hold_d;
    logic             sw_q, sw_d;
    logic             to_q, to_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        sel_d   = sel_q;
        to_d    = to_q;

        case (state_q)
            ST_BOOT: begin
                sel_d = req_s;
                if (cfg_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SettleLoad;
                end
            end
            ST_RUN: begin
                // Loss of config done takes priority: the clock is no longer trusted.
                if (!cfg_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = HoldLoad;
                end else if (req_s != sel_q) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = DebLoad;
                end
            end
            ST_DEBOUNCE: begin
                // With a 1-bit request any change here means it went back to the current select.
                if (req_s == sel_q) begin
                    state_d = ST_RUN;
                end else if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HoldLoad;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                sel_d   = req_s;
                state_d = ST_SETTLE;
                cnt_d   = SettleLoad;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_CFG;
                    cnt_d   = TimeoutLoad;
                end
            end
            ST_WAIT_CFG: begin
                if (cfg_s) begin
                    state_d = ST_RUN;
                end else if (cnt_q == '0) begin
                    to_d    = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = HoldLoad;
                end
            end
            default: begin
                state_d = ST_BOOT;
                cnt_d   = '0;
            end
        endcase

        // Registered so the HDMI async reset never sees decode glitches.
        hold_d = (state_d == ST_RUN) || (state_d == ST_DEBOUNCE);
        sw_d   = (state_d != ST_RUN);
    end

    always_ff @(posedge SYS_CLK_i) begin
        if (!nRST_i) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
            sel_q   <= SEL_MAIN;
            hold_q  <= 1'b0;
            sw_q    <= 1'b1;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            sw_q    <= sw_d;
            to_q    <= to_d;
        end
    end

    assign HDMI_CLK_sel_o   = sel_q;
    assign HDMI_hold_nRST_o = hold_q;
    assign switching_o      = sw_q;
    assign timeout_o        = to_q;

endmodule

// File: tb/tb_hdmi_clk_switch_ctrl.sv
// Directed-plus-random bench for hdmi_clk_switch_ctrl; expected timings come from the sequencing
// rules (each counted phase dwells load+1 cycles) and a committed-selection model.
module tb_hdmi_clk_switch_ctrl;
    import hdmi_clk_switch_ctrl_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HLD  = 4;
    localparam int SET  = 4;
    localparam int TMO  = 32;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic req  = 1'b0;
    logic cfg  = 1'b0;
    logic sel, hold, sw, to;

    always #5 clk = ~clk;

    hdmi_clk_switch_ctrl #(
        .SYNC_STAGES  (SYNC),
        .CNT_W        (20),
        .DEBOUNCE_CYC (DEB),
        .HOLD_CYC     (HLD),
        .SETTLE_CYC   (SET),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .SYS_CLK_i        (clk),
        .nRST_i           (nrst),
        .clk_sel_req_i    (req),
        .Si_cfg_done_i    (cfg),
        .HDMI_CLK_sel_o   (sel),
        .HDMI_hold_nRST_o (hold),
        .switching_o      (sw),
        .timeout_o        (to)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    logic prev_sel = 1'b0;
    logic prev_to  = 1'b0;
    logic msel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_chk++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
    endtask

    // One clock; outputs sampled 1 time unit after the edge, with running invariants.
    task automatic step();
        @(posedge clk);
        #1;
        if (sel !== prev_sel) chk("sel_changes_only_in_hold", {31'd0, hold}, 32'd0);
        if (nrst && prev_to) chk("timeout_sticky", {31'd0, to}, 32'd1);
        prev_sel = sel;
        prev_to  = to;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return hold;
            1:       return sel;
            2:       return to;
            default: return sw;
        endcase
    endfunction

    // Steps until the chosen output equals val; returns budget+1 if it never does.
    task automatic wait_sig(input int w, input logic val, input int budget, output int n);
        n = 0;
        while (sig(w) !== val && n <= budget) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, n1, n2, lows, len, kind;
        logic r;

        // Reset with request for sub clock and config not yet done
        req = 1'b1;
        cfg = 1'b0;
        repeat (3) step();
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_hold", {31'd0, hold}, 32'd0);
        chk("rst_switching", {31'd0, sw}, 32'd1);
        chk("rst_timeout", {31'd0, to}, 32'd0);

        nrst = 1'b1;
        repeat (20) step();
        chk("boot_sel_follows_req", {31'd0, sel}, 32'd1);
        chk("boot_hold_asserted", {31'd0, hold}, 32'd0);
        chk("boot_switching", {31'd0, sw}, 32'd1);

        cfg = 1'b1;
        wait_sig(0, 1'b1, 40, n);
        chk_rng("boot_release_cycles", n, SYNC + SET + 2, SYNC + SET + 4);
        chk("boot_switching_low", {31'd0, sw}, 32'd0);
        chk("boot_sel_kept", {31'd0, sel}, 32'd1);
        msel = 1'b1;

        // Mixed clean switches and short request glitches
        for (int i = 0; i < 6; i++) begin
            kind = (i < 2) ? i : int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) step();
            if (kind == 0) begin
                len  = int'($urandom_range(1, 5));
                lows = 0;
                req  = ~msel;
                repeat (len) begin
                    step();
                    if (hold !== 1'b1) lows++;
                end
                req = msel;
                repeat (20) begin
                    step();
                    if (hold !== 1'b1) lows++;
                end
                chk("glitch_no_hold_pulse", lows, 0);
                chk("glitch_sel_unchanged", {31'd0, sel}, {31'd0, msel});
                chk("glitch_back_in_run", {31'd0, sw}, 32'd0);
            end else begin
                req = ~msel;
                wait_sig(0, 1'b0, 40, n1);
                chk_rng("switch_hold_fall", n1, SYNC + DEB + 1, SYNC + DEB + 3);
                chk("switch_sel_not_yet", {31'd0, sel}, {31'd0, msel});
                wait_sig(1, ~msel, 40, n2);
                chk_rng("switch_latency", n1 + n2 - 1, SYNC + DEB + HLD + 2, SYNC + DEB + HLD + 4);
                wait_sig(0, 1'b1, 60, n);
                chk_rng("switch_hold_release", n, SET + 1, SET + 3);
                chk("switch_sel_new", {31'd0, sel}, {31'd0, ~msel});
                chk("switch_switching_low", {31'd0, sw}, 32'd0);
                msel = ~msel;
            end
        end

        // Config done lost right after the mux flips: timeout, then retry
        req = ~msel;
        wait_sig(1, ~msel, 40, n);
        chk_rng("to_sel_flip", n, SYNC + DEB + HLD + 3, SYNC + DEB + HLD + 5);
        msel = ~msel;
        cfg  = 1'b0;
        wait_sig(2, 1'b1, 80, n);
        chk_rng("to_timeout_cycles", n, SET + TMO + 1, SET + TMO + 3);
        chk("to_back_in_hold", {31'd0, hold}, 32'd0);
        cfg = 1'b1;
        wait_sig(0, 1'b1, 60, n);
        chk_rng("to_retry_release", n, 1, 60);
        chk("to_timeout_stays", {31'd0, to}, 32'd1);
        chk("to_sel_kept", {31'd0, sel}, {31'd0, msel});

        // Config drop while running
        repeat ($urandom_range(1, 4)) step();
        cfg = 1'b0;
        wait_sig(0, 1'b0, 20, n);
        chk_rng("cfgdrop_hold_fall", n, 1, SYNC + 1);
        repeat (3) step();
        cfg = 1'b1;
        wait_sig(0, 1'b1, 60, n);
        chk_rng("cfgdrop_recover", n, 1, 60);
        chk("cfgdrop_sel_kept", {31'd0, sel}, {31'd0, msel});
        chk("cfgdrop_timeout_kept", {31'd0, to}, 32'd1);

        // Reset asserted during settle
        req = ~msel;
        wait_sig(1, ~msel, 40, n);
        step();
        step();
        nrst = 1'b0;
        step();
        chk("midrst_sel", {31'd0, sel}, 32'd0);
        chk("midrst_hold", {31'd0, hold}, 32'd0);
        chk("midrst_switching", {31'd0, sw}, 32'd1);
        chk("midrst_timeout", {31'd0, to}, 32'd0);
        chk("midrst_state", {29'd0, dut.state_q}, {29'd0, ST_BOOT});
        step();
        r    = 1'($urandom_range(0, 1));
        req  = r;
        nrst = 1'b1;
        wait_sig(0, 1'b1, 60, n);
        chk_rng("postrst_release", n, SYNC + SET + 2, SYNC + SET + 6);
        chk("postrst_sel", {31'd0, sel}, {31'd0, r});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
